// File: rtl/ptltx_array_clk.sv
// Multi-channel toggle-encoded PTL transmitter: startup blanking, hold enforcement, fixed latency.
// Define PTLTX_DROP_CNT_EN to add saturating per-channel drop counters on drop_cnt.
module ptltx_array_clk #(
  parameter int unsigned CHANNELS     = 4,
  parameter int unsigned DELAY        = 2,
  parameter int unsigned HOLD         = 3,
  parameter int unsigned BEGIN_CYCLES = 8,
  parameter int unsigned CNT_W        = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS-1:0]       a,
  output logic [CHANNELS-1:0]       q,
  output logic                      ready,
  output logic [CHANNELS-1:0]       viol
`ifdef PTLTX_DROP_CNT_EN
  ,
  output logic [CHANNELS*CNT_W-1:0] drop_cnt
`endif
);

  localparam int unsigned BlankW = $clog2(BEGIN_CYCLES + 1);
  localparam int unsigned CoolW  = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [BlankW-1:0] BlankLast = BlankW'(BEGIN_CYCLES - 1);
  localparam logic [CoolW-1:0]  CoolLoad  = CoolW'(HOLD - 1);

  logic [CHANNELS-1:0] a_prev_q;
  logic [CHANNELS-1:0] pulse;
  logic [CHANNELS-1:0] accept;
  logic [CHANNELS-1:0] drop;
  logic [BlankW-1:0]   blank_q, blank_d;
  logic                ready_q, ready_d;
  logic [CoolW-1:0]    cool_q [CHANNELS];
  logic [CoolW-1:0]    cool_d [CHANNELS];
  logic [CHANNELS-1:0] pipe_q [DELAY];
  logic [CHANNELS-1:0] q_q, q_d;
  logic [CHANNELS-1:0] viol_q;

  always_comb begin
    pulse   = a ^ a_prev_q;
    accept  = '0;
    drop    = '0;
    for (int unsigned ch = 0; ch < CHANNELS; ch++) begin
      cool_d[ch] = cool_q[ch];
      // Drops leave the cooldown running so spacing is measured from the last accepted pulse.
      if (ready_q && pulse[ch]) begin
        if (cool_q[ch] == '0) accept[ch] = 1'b1;
        else                  drop[ch]   = 1'b1;
      end
      if (accept[ch])              cool_d[ch] = CoolLoad;
      else if (cool_q[ch] != '0)   cool_d[ch] = cool_q[ch] - CoolW'(1);
    end
    ready_d = ready_q | (blank_q == BlankLast);
    blank_d = ready_q ? blank_q : blank_q + BlankW'(1);
    q_d     = q_q ^ pipe_q[DELAY-1];
  end

  always_ff @(posedge clk) begin
    // Capturing a during reset keeps reset release from looking like a pulse.
    a_prev_q <= a;
    if (!rst_n) begin
      blank_q <= '0;
      ready_q <= 1'b0;
      q_q     <= '0;
      viol_q  <= '0;
      for (int unsigned ch = 0; ch < CHANNELS; ch++) cool_q[ch] <= '0;
      for (int unsigned s = 0; s < DELAY; s++) pipe_q[s] <= '0;
    end else begin
      blank_q <= blank_d;
      ready_q <= ready_d;
      q_q     <= q_d;
      viol_q  <= drop;
      for (int unsigned ch = 0; ch < CHANNELS; ch++) cool_q[ch] <= cool_d[ch];
      pipe_q[0] <= accept;
      for (int unsigned s = 1; s < DELAY; s++) pipe_q[s] <= pipe_q[s-1];
    end
  end

  assign q     = q_q;
  assign ready = ready_q;
  assign viol  = viol_q;

`ifdef PTLTX_DROP_CNT_EN
  logic [CNT_W-1:0] cnt_q [CHANNELS];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned ch = 0; ch < CHANNELS; ch++) cnt_q[ch] <= '0;
    end else begin
      for (int unsigned ch = 0; ch < CHANNELS; ch++) begin
        if (drop[ch] && (cnt_q[ch] != '1)) cnt_q[ch] <= cnt_q[ch] + CNT_W'(1);
      end
    end
  end

  always_comb begin
    drop_cnt = '0;
    for (int unsigned ch = 0; ch < CHANNELS; ch++) drop_cnt[ch*CNT_W +: CNT_W] = cnt_q[ch];
  end
`endif

endmodule

// File: tb/tb_ptltx_array_clk.sv
// Scoreboard bench for ptltx_array_clk: event-time reference model, directed plan then random traffic.
module tb_ptltx_array_clk;

  localparam int unsigned CHANNELS     = 4;
  localparam int unsigned DELAY        = 2;
  localparam int unsigned HOLD         = 3;
  localparam int unsigned BEGIN_CYCLES = 8;
  localparam int unsigned CNT_W        = 8;
  localparam int          CntMax       = (1 << CNT_W) - 1;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [CHANNELS-1:0] a = '0;
  logic [CHANNELS-1:0] q;
  logic [CHANNELS-1:0] viol;
  logic                ready;
`ifdef PTLTX_DROP_CNT_EN
  logic [CHANNELS*CNT_W-1:0] drop_cnt;
`endif

  ptltx_array_clk #(
    .CHANNELS    (CHANNELS),
    .DELAY       (DELAY),
    .HOLD        (HOLD),
    .BEGIN_CYCLES(BEGIN_CYCLES),
    .CNT_W       (CNT_W)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .a       (a),
    .q       (q),
    .ready   (ready),
    .viol    (viol)
`ifdef PTLTX_DROP_CNT_EN
    ,
    .drop_cnt(drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [CHANNELS-1:0]       q;
    logic [CHANNELS-1:0]       viol;
    logic                      ready;
    logic [CHANNELS*CNT_W-1:0] cnt;
  } exp_t;

  exp_t sb[$];
  int   n_vec  = 0;
  int   n_fail = 0;

  // Reference model: absolute edge times of accepted pulses and scheduled output toggles.
  int                  cyc = 0;
  int                  since_rel = 0;
  logic [CHANNELS-1:0] m_prev = '0;
  logic [CHANNELS-1:0] m_q = '0;
  logic [CHANNELS-1:0] m_viol = '0;
  logic                m_ready = 1'b0;
  int                  last_acc [CHANNELS];
  int                  m_cnt [CHANNELS];
  logic [CHANNELS-1:0] pend [int];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at t=%0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic model_edge(input logic r, input logic [CHANNELS-1:0] av);
    logic [CHANNELS-1:0] sched;
    exp_t e;
    cyc++;
    if (!r) begin
      m_q = '0; m_viol = '0; m_ready = 1'b0; since_rel = 0;
      pend.delete();
      for (int ch = 0; ch < CHANNELS; ch++) begin
        last_acc[ch] = -1000;
        m_cnt[ch] = 0;
      end
    end else begin
      since_rel++;
      m_viol = '0;
      sched = '0;
      if (pend.exists(cyc)) begin
        m_q ^= pend[cyc];
        pend.delete(cyc);
      end
      for (int ch = 0; ch < CHANNELS; ch++) begin
        if (m_ready && (av[ch] != m_prev[ch])) begin
          if (cyc - last_acc[ch] >= HOLD) begin
            last_acc[ch] = cyc;
            sched[ch] = 1'b1;
          end else begin
            m_viol[ch] = 1'b1;
            if (m_cnt[ch] < CntMax) m_cnt[ch]++;
          end
        end
      end
      if (sched != '0) pend[cyc + DELAY] = sched;
      if (since_rel >= BEGIN_CYCLES) m_ready = 1'b1;
    end
    m_prev = av;
    e.q = m_q;
    e.viol = m_viol;
    e.ready = m_ready;
    e.cnt = '0;
    for (int ch = 0; ch < CHANNELS; ch++) e.cnt[ch*CNT_W +: CNT_W] = CNT_W'(m_cnt[ch]);
    sb.push_back(e);
  endtask

  // Drive inputs for the next edge, push its expected result, then advance past that edge.
  task automatic apply(input logic r, input logic [CHANNELS-1:0] tog);
    rst_n = r;
    a = a ^ tog;
    model_edge(r, a);
    @(posedge clk);
    #1;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("ready", 32'(ready), 32'(e.ready));
        check("q", 32'(q), 32'(e.q));
        check("viol", 32'(viol), 32'(e.viol));
`ifdef PTLTX_DROP_CNT_EN
        for (int ch = 0; ch < CHANNELS; ch++)
          check("drop_cnt", 32'(drop_cnt[ch*CNT_W +: CNT_W]), 32'(e.cnt[ch*CNT_W +: CNT_W]));
`endif
      end
    end
  end

  initial begin : stim
    logic [CHANNELS-1:0] tog;
    int                  dens;
    for (int ch = 0; ch < CHANNELS; ch++) begin
      last_acc[ch] = -1000;
      m_cnt[ch] = 0;
    end

    repeat (3) apply(1'b0, '0);

    // Directed plan, edges numbered from the first edge with rst_n high.
    for (int e = 1; e <= 80; e++) begin
      case (e)
        3:       tog = 4'b0001;
        20:      tog = 4'b0010;
        30, 31:  tog = 4'b0100;
        40, 43:  tog = 4'b1000;
        50:      tog = 4'b1111;
        60:      tog = 4'b0001;
        default: tog = 4'b0000;
      endcase
      apply((e == 61) ? 1'b0 : 1'b1, tog);
    end

    // Saturate the channel-0 drop counter with back-to-back toggles.
    apply(1'b0, '0);
    repeat (BEGIN_CYCLES + 2) apply(1'b1, '0);
    repeat (480) apply(1'b1, 4'b0001);
    repeat (5) apply(1'b1, '0);

    // Random traffic with varying density and occasional resets.
    dens = 30;
    for (int i = 0; i < 3000; i++) begin
      if (i % 100 == 0) dens = $urandom_range(5, 90);
      tog = '0;
      for (int ch = 0; ch < CHANNELS; ch++) tog[ch] = ($urandom_range(0, 99) < dens);
      apply(($urandom_range(0, 249) == 0) ? 1'b0 : 1'b1, tog);
    end

    for (int i = 0; i < 5 && sb.size() > 0; i++) begin
      @(negedge clk);
      #1;
    end
    if (sb.size() != 0) begin
      n_vec++;
      n_fail++;
      $display("FAIL drain: got %0d pending expectations, expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
